// File: rtl/ct_pt_add.sv
// ct_pt_add: registered slot-wise BFV ciphertext-plaintext add, B' = (B + delta*gamma) mod q, A' = A mod q
package ct_pt_add_pkg;
  localparam int N = 8;
  localparam int W = 16;
  localparam int WW = 2 * W;
  typedef logic [N-1:0][W-1:0] vec_t;
  typedef vec_t pt_t;
  typedef struct packed {
    vec_t a;
    vec_t b;
  } ct_t;
endpackage

module ct_pt_add
  import ct_pt_add_pkg::*;
#(
  parameter int unsigned QP = 7710,
  parameter int unsigned DELTAP = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  ct_t  in_ct,
  input  pt_t  in_gamma,
  output logic out_valid,
  output ct_t  out_ct
);
  localparam logic [W-1:0] Q = W'(QP);
  localparam logic [WW-1:0] QW = WW'(QP);
  localparam logic [WW-1:0] DW = WW'(DELTAP);
  ct_t nxt;
  for (genvar i = 0; i < N; i++) begin : g_s
    logic [WW-1:0] p, s;
    logic [W-1:0] b_r, p_r;
    assign p = DW * WW'(in_gamma[i]);
    assign p_r = W'(p % QW);
    assign b_r = in_ct.b[i] % Q;
    assign s = WW'(b_r) + WW'(p_r);
    assign nxt.a[i] = in_ct.a[i] % Q;
    assign nxt.b[i] = W'(s >= QW ? s - QW : s);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ct <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_ct <= nxt;
    end
  end
endmodule

// File: tb/tb_ct_pt_add.sv
// tb_ct_pt_add: scoreboard bench for ct_pt_add with directed, hand-computed vectors
module tb_ct_pt_add;
  import ct_pt_add_pkg::*;
  logic clk = 0, rst = 1, in_valid = 0, out_valid;
  ct_t in_ct, out_ct, last;
  pt_t in_gamma;
  ct_t expq[$];
  int checks = 0, errors = 0;

  ct_pt_add #(.QP(7710), .DELTAP(30)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ct(in_ct),
    .in_gamma(in_gamma), .out_valid(out_valid), .out_ct(out_ct)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid !== 1'b0) begin
      if (expq.size() == 0) chk("unexpected_out_valid", 256'(out_valid), 256'(0));
      else chk("scoreboard_out_ct", out_ct, expq.pop_front());
    end
  end

  task automatic drive(input int a[N], input int b[N], input int g[N], input int ea[N], input int eb[N]);
    ct_t e;
    @(negedge clk);
    in_valid = 1;
    for (int i = 0; i < N; i++) begin
      in_ct.a[i] = W'(a[i]);
      in_ct.b[i] = W'(b[i]);
      in_gamma[i] = W'(g[i]);
      e.a[i] = W'(ea[i]);
      e.b[i] = W'(eb[i]);
    end
    expq.push_back(e);
    last = e;
  endtask

  task automatic bcast(input int a, input int b, input int g, input int ea, input int eb);
    int va[N], vb[N], vg[N], vea[N], veb[N];
    for (int i = 0; i < N; i++) begin
      va[i] = a; vb[i] = b; vg[i] = g; vea[i] = ea; veb[i] = eb;
    end
    drive(va, vb, vg, vea, veb);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 0;
  endtask

  int na[N] = '{1429, 4717, 6311, 3279, 7215, 6215, 6931, 973};
  int nb[N] = '{7531, 4381, 1094, 7529, 5909, 964, 5576, 4640};
  int ng[N] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int nbe[N] = '{7561, 4441, 1184, 7649, 6059, 1144, 5786, 4880};
  int wa[N] = '{7710, 65535, 0, 7709, 1, 7711, 15420, 3};
  int wae[N] = '{0, 3855, 0, 7709, 1, 1, 0, 3};
  int wb[N] = '{7700, 1000, 7709, 5, 5, 0, 65535, 7710};
  int wg[N] = '{1, 1000, 0, 257, 65535, 0, 0, 257};
  int wbe[N] = '{20, 160, 7709, 5, 5, 0, 3855, 0};

  initial begin
    in_valid = 1;
    in_ct = {16{16'h1234}};
    in_gamma = {8{16'd7}};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 256'(out_valid), 256'(0));
    chk("reset_out_ct", out_ct, 256'(0));
    @(negedge clk);
    rst = 0;
    in_valid = 0;
    drive(na, nb, ng, na, nbe);
    idle();
    chk("nominal_latency_valid", 256'(out_valid), 256'(1));
    drive(wa, wb, wg, wae, wbe);
    idle();
    @(negedge clk);
    chk("valid_drops", 256'(out_valid), 256'(0));
    chk("hold_after_idle", out_ct, last);
    bcast(10, 100, 2, 10, 160);
    bcast(7720, 7000, 30, 10, 190);
    bcast(1, 2, 3, 1, 92);
    bcast(65535, 65535, 65535, 3855, 3855);
    idle();
    repeat (3) @(negedge clk);
    chk("stream_valid_drops", 256'(out_valid), 256'(0));
    chk("stream_hold_last", out_ct, last);
    bcast(5, 5, 5, 5, 155);
    @(negedge clk);
    in_valid = 1;
    rst = 1;
    @(posedge clk);
    #1;
    chk("midreset_out_valid", 256'(out_valid), 256'(0));
    chk("midreset_out_ct", out_ct, 256'(0));
    @(negedge clk);
    rst = 0;
    in_valid = 0;
    repeat (3) @(negedge clk);
    chk("midreset_no_stale", 256'(out_valid), 256'(0));
    bcast(7710, 7709, 257, 0, 7709);
    idle();
    for (int t = 0; t < 20 && expq.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 256'(expq.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
